// File: rtl/mips_pkg.sv
// Shared definitions for the mini-MIPS core: datapath widths, the reset PC
// and the fetch-stage state encoding.
package mips_pkg;

  localparam int PC_W    = 15;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the word-addressed PC, issues one instruction-memory read
// at a time and hands each instruction downstream through valid/ready.
module instr_fetch_stage #(
  parameter int              PC_W     = mips_pkg::PC_W,
  parameter int              INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_control,
  input  logic [PC_W-1:0]    j_instr_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [15:0]        fetch_count
);

  import mips_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            accept;
  logic            capture;

  assign accept  = instr_valid & instr_ready;
  // Responses outside WAIT are stale or unsolicited and are simply dropped.
  assign capture = (state_q == WAIT) & imem_rvalid;

  // Increment wraps naturally at the top of the PC range.
  assign pc_next = PC_control ? j_instr_addr : pc + PC_W'(1);

  assign imem_addr = pc;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (imem_rvalid) state_d = HOLD;
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (accept) begin
        pc <= pc_next;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a variable-latency memory model.
module tb_instr_fetch_stage;

  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PC_control = 1'b0;
  logic [14:0] j_instr_addr = '0;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [14:0] instr_pc;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_count = 0;

  instr_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PC_control   (PC_control),
    .j_instr_addr (j_instr_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] md(input logic [14:0] a);
    return 32'hA5A5_0000 + {17'd0, a} + 32'd1;
  endfunction

  // Memory model: responds `latency` cycles after the request.
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        pend;
  logic [14:0] paddr;
  int          lat_cnt;
  int          latency = 1;
  logic        stray = 1'b0;

  assign imem_rvalid = mem_rvalid | stray;
  assign imem_rdata  = stray ? 32'hDEAD_BEEF : mem_rdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      pend       <= 1'b0;
      paddr      <= '0;
      lat_cnt    <= 0;
    end else begin
      mem_rvalid <= 1'b0;
      if (imem_req) begin
        if (latency <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= md(imem_addr);
        end else begin
          pend    <= 1'b1;
          lat_cnt <= latency - 1;
          paddr   <= imem_addr;
        end
      end else if (pend) begin
        if (lat_cnt == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= md(paddr);
          pend       <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One full fetch of exp_addr; optionally holds off acceptance for
  // hold_cycles (with a stray response mid-way), then accepts.
  task automatic fetch(input logic [14:0] exp_addr, input logic jump,
                       input logic [14:0] target, input int hold_cycles,
                       output int req_c, output int val_c);
    int n;
    int reqs;
    int unstable;
    logic [14:0] nxt;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("req_seen", imem_req, 1);
    check("imem_addr", imem_addr, exp_addr);
    req_c = cyc;
    @(negedge clk);
    n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    check("instr_valid", instr_valid, 1);
    check("instr", instr, md(exp_addr));
    check("instr_pc", instr_pc, exp_addr);
    val_c = cyc;
    if (hold_cycles > 0) begin
      reqs = 0;
      unstable = 0;
      for (int i = 0; i < hold_cycles; i++) begin
        stray = (i == 3);
        @(negedge clk);
        if (imem_req) reqs++;
        if (instr !== md(exp_addr) || instr_pc !== exp_addr || !instr_valid) unstable++;
      end
      stray = 1'b0;
      check("bp_no_req", reqs, 0);
      check("bp_instr_stable", unstable, 0);
    end
    PC_control   = jump;
    j_instr_addr = target;
    instr_ready  = 1'b1;
    @(negedge clk);
    instr_ready  = 1'b0;
    // Junk jump request outside accept must be ignored.
    PC_control   = 1'b1;
    j_instr_addr = 15'h5555;
    exp_count++;
    nxt = jump ? target : exp_addr + 15'd1;
    check("fetch_count", fetch_count, exp_count);
    check("next_addr", imem_addr, nxt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int rel, r0, v0, r1, v1;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_count", fetch_count, 0);

    reset = 1'b1;
    rel = cyc;
    #1 check("idle_no_req", imem_req, 0);

    fetch(15'd0, 1'b0, 15'd0, 0, r0, v0);
    check("first_req_cycle", r0 - rel, 1);
    check("first_valid_cycle", v0 - rel, 3);
    check("first_instr_value", instr, 32'hA5A5_0001);

    instr_ready = 1'b0;
    fetch(15'd1, 1'b0, 15'd0, 0, r1, v1);
    check("spacing_1", r1 - r0, 3);
    r0 = r1;
    fetch(15'd2, 1'b0, 15'd0, 0, r1, v1);
    check("spacing_2", r1 - r0, 3);
    r0 = r1;
    fetch(15'd3, 1'b1, 15'h0123, 0, r1, v1);
    check("spacing_3", r1 - r0, 3);
    check("count_after_4", fetch_count, 16'd4);

    fetch(15'h0123, 1'b1, 15'h7FFF, 0, r1, v1);
    fetch(15'h7FFF, 1'b0, 15'd0, 0, r1, v1);
    check("wrap_addr", imem_addr, 15'h0000);

    latency = 5;
    fetch(15'h0000, 1'b0, 15'd0, 10, r1, v1);
    check("lat5_valid_delay", v1 - r1, 6);

    // Reset in the middle of a slow read.
    @(negedge clk);
    @(negedge clk);
    check("mid_wait_addr", imem_addr, 15'h0001);
    reset = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_instr", instr, 0);
    check("arst_instr_pc", instr_pc, 0);
    check("arst_count", fetch_count, 0);
    @(negedge clk);
    latency = 1;
    exp_count = 0;
    PC_control = 1'b0;
    reset = 1'b1;
    rel = cyc;
    fetch(15'd0, 1'b0, 15'd0, 0, r0, v0);
    check("restart_req_cycle", r0 - rel, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Fetch stage of the IITK mini-MIPS core, sitting directly upstream of `control_unit`. It owns the architectural 15-bit word-addressed PC and issues one instruction-memory read at a time. It presents each returned instruction with its PC through a valid/ready handshake. On each accepted instruction it advances the PC to either PC+1 or the jump target (`PC_control`/`j_instr_addr`) supplied back by the control unit.

## Interface
- `PC_W`, 15, PC width (word address)
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 15'd0, first fetch address after reset

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `PC_control`  in  1  1 = take jump on the accepted instruction, 0 = sequential
- `j_instr_addr`  in  PC_W  jump target, valid with `PC_control`
- `imem_req`  out  1  read request strobe, one cycle per fetch
- `imem_addr`  out  PC_W  read address, equals current PC
- `imem_rvalid`  in  1  read data valid, one-cycle pulse
- `imem_rdata`  in  INSTR_W  read data
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction
- `instr_ready`  in  1  downstream accepts the instruction this cycle
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  PC_W  address of `instr`
- `fetch_count`  out  16  instructions accepted since reset, saturating at 16'hFFFF

## Operation
- Four-state FSM:
  - IDLE: entered on reset; lasts one cycle, then goes to REQ.
  - REQ: `imem_req`=1 for exactly one cycle with `imem_addr`=pc, then goes to WAIT.
  - WAIT: holds until `imem_rvalid`=1. Registers `imem_rdata` into `instr` and pc into `instr_pc`, then goes to HOLD.
  - HOLD: `instr_valid`=1; `instr` and `instr_pc` stay stable until accepted.
- Accept means `instr_valid & instr_ready`, possible only in HOLD. On accept:
  - pc <= `PC_control` ? `j_instr_addr` : pc+1. The increment wraps modulo 2^PC_W (7FFF -> 0000).
  - `fetch_count` increments, unless it is saturated.
  - FSM goes to REQ.
- `PC_control` and `j_instr_addr` are sampled only on the accept cycle and ignored at all other times.
- `imem_rvalid` is ignored in IDLE, REQ and HOLD; stale or unsolicited responses are dropped.
- At most one request is outstanding.
- `imem_addr` always drives pc, including outside REQ.
- Reset at any time, including mid-WAIT, returns everything to reset values immediately. The instruction memory is reset by the same `reset` net, so no response from before reset arrives in WAIT.

## Timing
- Reset values:
  - state: IDLE
  - pc and `imem_addr`: `RESET_PC`
  - `imem_req`: 0
  - `instr_valid`: 0
  - `instr`: 0
  - `instr_pc`: 0
  - `fetch_count`: 0
- After `reset` deasserts: cycle 0 is IDLE; `imem_req` asserts in cycle 1.
- With 1-cycle memory latency:
  - REQ at cycle t.
  - `imem_rvalid` at t+1.
  - `instr_valid` at t+2.
  - If `instr_ready`=1 at t+2, the next REQ is at t+3.
  - Steady-state throughput is therefore 1 instruction per 3 cycles.
- `imem_req` and `instr_valid` are decoded from the state register; all other outputs come straight from flops.
- Back-pressure: with `instr_ready` low, HOLD persists indefinitely and no new request is issued.

## Structure
- Shared package `mips_pkg` holds:
  - constants `PC_W`=15, `INSTR_W`=32, `RESET_PC`
  - the fetch-state enum `fetch_state_t` {IDLE, REQ, WAIT, HOLD}
- Single module; no sub-module. The next-PC mux (+1 vs jump) is inline logic and stays arithmetically identical to `PC_incr`.

## Test plan
- Reset release with 1-cycle memory returning `imem_rdata`=32'hA5A5_0001 -> `imem_req` in cycle 1 at addr 0. Then `instr_valid` in cycle 3 with `instr`=32'hA5A5_0001 and `instr_pc`=0.
- Sequential run with `instr_ready`=1 and `PC_control`=0 -> addresses 0,1,2,3, one request every 3 cycles; `fetch_count`=4 after the fourth accept.
- Jump: accept with `PC_control`=1 and `j_instr_addr`=15'h0123 -> next `imem_addr`=15'h0123.
- Wrap and back-pressure:
  - Jump to 15'h7FFF, then accept sequentially -> next address 15'h0000.
  - `instr_ready`=0 for 10 cycles -> `instr` stable, no `imem_req`.
- Stray responses and reset:
  - `imem_rvalid` pulse in HOLD -> `instr` unchanged.
  - Memory latency of 5 cycles -> correct capture.
  - `reset` asserted mid-WAIT -> all outputs at reset values asynchronously; after release, fetch restarts at `RESET_PC`.
